// File: rtl/regfile_dump_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : regfile_dump_loader_if
// Brief   : Dump stream, load stream and register-file port of the sequencer.
// Revision: 1.0
// ============================================================================
interface regfile_dump_loader_if #(
  parameter int NREGS = 32,
  parameter int DW    = 32
);
  localparam int c_IW = $clog2(NREGS);

  logic            dump_valid;
  logic            dump_ready;
  logic [DW-1:0]   dump_data;
  logic [c_IW-1:0] dump_idx;

  logic            load_valid;
  logic            load_ready;
  logic [DW-1:0]   load_data;

  logic [c_IW-1:0] rf_rsel1;
  logic [DW-1:0]   rf_rdat1;
  logic            rf_WEN;
  logic [c_IW-1:0] rf_wsel;
  logic [DW-1:0]   rf_wdat;

  modport master (
    output dump_valid, dump_data, dump_idx,
    input  dump_ready,
    input  load_valid, load_data,
    output load_ready,
    output rf_rsel1,
    input  rf_rdat1,
    output rf_WEN, rf_wsel, rf_wdat
  );

  modport slave (
    input  dump_valid, dump_data, dump_idx,
    output dump_ready,
    output load_valid, load_data,
    input  load_ready,
    input  rf_rsel1,
    output rf_rdat1,
    input  rf_WEN, rf_wsel, rf_wdat
  );
endinterface
`default_nettype wire

// File: rtl/regfile_dump_loader.sv
`default_nettype none
// ============================================================================
// Module  : regfile_dump_loader
// Brief   : Dumps the whole register file to a stream, or loads it from one.
// Revision: 1.0
// ============================================================================
module regfile_dump_loader #(
  parameter int NREGS          = 32,
  parameter int DW             = 32,
  parameter int LOAD_SKIP_ZERO = 1
) (
  input  wire logic clk,
  input  wire logic n_rst,
  input  wire logic start_dump,
  input  wire logic start_load,
  input  wire logic abort,
  output logic      busy,
  output logic      done,
  regfile_dump_loader_if.master bus
);

  localparam int              c_IW         = $clog2(NREGS);
  localparam logic [c_IW-1:0] c_LAST       = c_IW'(NREGS - 1);
  localparam logic [c_IW-1:0] c_LOAD_START = (LOAD_SKIP_ZERO != 0) ? c_IW'(1) : '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DUMP  = 3'd1,
    S_DRAIN = 3'd2,
    S_LOAD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  logic [c_IW-1:0] r_idx;
  logic            r_dump_valid;
  logic [DW-1:0]   r_dump_data;
  logic [c_IW-1:0] r_dump_idx;

  logic w_beat_load;
  logic w_load_hs;
  logic w_last;

  // Output slot refills when empty or when its current beat is being taken.
  assign w_beat_load = (r_state == S_DUMP) && (!r_dump_valid || bus.dump_ready);
  assign w_load_hs   = (r_state == S_LOAD) && bus.load_valid;
  assign w_last      = (r_idx == c_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_dump_valid <= 1'b0;
      r_dump_data  <= '0;
      r_dump_idx   <= '0;
    end else if (abort && (r_state != S_IDLE)) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_dump_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_dump) begin
            r_state <= S_DUMP;
            r_idx   <= '0;
          end else if (start_load) begin
            r_state <= S_LOAD;
            r_idx   <= c_LOAD_START;
          end
        end
        S_DUMP: begin
          if (w_beat_load) begin
            r_dump_data  <= bus.rf_rdat1;
            r_dump_idx   <= r_idx;
            r_dump_valid <= 1'b1;
            // Terminal index is checked before incrementing so idx never wraps.
            if (w_last) begin
              r_state <= S_DRAIN;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (r_dump_valid && bus.dump_ready) begin
            r_dump_valid <= 1'b0;
            r_state      <= S_DONE;
          end
        end
        S_LOAD: begin
          if (w_load_hs) begin
            if (w_last) begin
              r_state <= S_DONE;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_idx        <= '0;
          r_dump_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  assign bus.dump_valid = r_dump_valid;
  assign bus.dump_data  = r_dump_data;
  assign bus.dump_idx   = r_dump_idx;

  assign bus.load_ready = (r_state == S_LOAD);

  // Write strobe follows the load handshake in the same cycle, including an abort cycle.
  assign bus.rf_rsel1 = (r_state == S_DUMP) ? r_idx : '0;
  assign bus.rf_WEN   = w_load_hs;
  assign bus.rf_wsel  = w_load_hs ? r_idx : '0;
  assign bus.rf_wdat  = w_load_hs ? bus.load_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_dump_loader
// Brief   : Scoreboard bench for regfile_dump_loader with a behavioural regfile.
// Revision: 1.0
// ============================================================================
module tb_regfile_dump_loader;

  localparam int NREGS = 32;
  localparam int DW    = 32;
  localparam int IW    = 5;

  logic clk = 1'b0;
  logic n_rst;
  logic start_dump;
  logic start_load;
  logic abort;
  logic busy;
  logic done;

  always #5 clk = ~clk;

  regfile_dump_loader_if #(.NREGS(NREGS), .DW(DW)) bus ();

  regfile_dump_loader #(.NREGS(NREGS), .DW(DW), .LOAD_SKIP_ZERO(1)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start_dump (start_dump),
    .start_load (start_load),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  // Behavioural register file with a bench preload port.
  logic [DW-1:0] rf [NREGS];
  logic          pre_we;
  logic [IW-1:0] pre_idx;
  logic [DW-1:0] pre_dat;

  always @(posedge clk) begin
    if (pre_we) rf[pre_idx] <= pre_dat;
    else if (bus.rf_WEN) rf[bus.rf_wsel] <= bus.rf_wdat;
  end
  assign bus.rf_rdat1 = rf[bus.rf_rsel1];

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_dump[$];
  beat_t exp_wr[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_total = 0;
  int hs_cyc[$];
  int done_total = 0;
  int last_evt   = -100;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: samples on the falling edge, pops expectations on every handshake.
  logic          p_stall = 1'b0;
  logic          p_abort = 1'b0;
  logic          p_done  = 1'b0;
  logic [DW-1:0] p_data;
  logic [IW-1:0] p_idx;

  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (n_rst) begin
      if (bus.dump_valid && bus.dump_ready) begin
        chk("dump_beat_expected", 64'(exp_dump.size() > 0), 1);
        if (exp_dump.size() > 0) begin
          b = exp_dump.pop_front();
          chk("dump_idx", 64'(bus.dump_idx), 64'(b.idx));
          chk("dump_data", 64'(bus.dump_data), 64'(b.data));
        end
        hs_total++;
        hs_cyc.push_back(cyc);
        last_evt = cyc;
      end
      if (bus.rf_WEN) begin
        chk("write_expected", 64'(exp_wr.size() > 0), 1);
        if (exp_wr.size() > 0) begin
          b = exp_wr.pop_front();
          chk("rf_wsel", 64'(bus.rf_wsel), 64'(b.idx));
          chk("rf_wdat", 64'(bus.rf_wdat), 64'(b.data));
        end
        last_evt = cyc;
      end
      if (p_stall && !p_abort) begin
        chk("stall_valid_held", 64'(bus.dump_valid), 1);
        chk("stall_data_held", 64'(bus.dump_data), 64'(p_data));
        chk("stall_idx_held", 64'(bus.dump_idx), 64'(p_idx));
      end
      if (done) begin
        done_total++;
        chk("done_after_last_beat", 64'(cyc - last_evt), 1);
        chk("done_queues_empty", 64'(exp_dump.size() + exp_wr.size()), 0);
        chk("done_single_cycle", 64'(p_done), 0);
      end
    end
    p_stall = n_rst && bus.dump_valid && !bus.dump_ready;
    p_abort = abort;
    p_done  = n_rst && done;
    p_data  = bus.dump_data;
    p_idx   = bus.dump_idx;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic d, input logic l);
    start_dump = d;
    start_load = l;
    tick();
    start_dump = 1'b0;
    start_load = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    chk(name, 64'(busy), 0);
  endtask

  task automatic load_beat(input logic [DW-1:0] d);
    int k = 0;
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    while (!bus.load_ready && k < 20) begin
      tick();
      k++;
    end
    chk("load_ready_seen", 64'(bus.load_ready), 1);
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic push_dump(input int first, input int last, input logic zero_a);
    beat_t b;
    for (int i = first; i <= last; i++) begin
      b.idx  = IW'(i);
      b.data = zero_a ? ((i == 0) ? 32'h0 : (32'hA000_0000 + 32'(i))) : (32'(i) * 32'h11);
      exp_dump.push_back(b);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_dump_valid"}, 64'(bus.dump_valid), 0);
    chk({tag, "_dump_data"}, 64'(bus.dump_data), 0);
    chk({tag, "_dump_idx"}, 64'(bus.dump_idx), 0);
    chk({tag, "_load_ready"}, 64'(bus.load_ready), 0);
    chk({tag, "_rf_rsel1"}, 64'(bus.rf_rsel1), 0);
    chk({tag, "_rf_WEN"}, 64'(bus.rf_WEN), 0);
    chk({tag, "_rf_wsel"}, 64'(bus.rf_wsel), 0);
    chk({tag, "_rf_wdat"}, 64'(bus.rf_wdat), 0);
  endtask

  initial begin
    int base;
    int dbase;
    int c0;
    beat_t b;

    n_rst = 1'b0;
    start_dump = 1'b0;
    start_load = 1'b0;
    abort = 1'b0;
    bus.dump_ready = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    pre_we  = 1'b0;
    pre_idx = '0;
    pre_dat = '0;

    #12;
    check_idle_outputs("reset");
    tick();
    n_rst = 1'b1;
    tick();
    chk("post_reset_busy", 64'(busy), 0);

    pre_we = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      pre_idx = IW'(i);
      pre_dat = 32'(i) * 32'h11;
      tick();
    end
    pre_we = 1'b0;

    // Full-rate dump.
    bus.dump_ready = 1'b1;
    push_dump(0, 31, 1'b0);
    base = hs_total;
    dbase = done_total;
    c0 = cyc;
    pulse(1'b1, 1'b0);
    wait_idle("dump1_finish");
    tick();
    chk("dump1_beats", 64'(hs_total - base), 32);
    chk("dump1_first_latency", 64'(hs_cyc[base] - c0), 3);
    chk("dump1_back_to_back", 64'(hs_cyc[base + 31] - hs_cyc[base]), 31);
    chk("dump1_done_count", 64'(done_total - dbase), 1);

    // Dump with consumer stalls (ready pattern 1,0,0,1).
    push_dump(0, 31, 1'b0);
    base = hs_total;
    dbase = done_total;
    start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    for (int c = 0; c < 400 && busy; c++) begin
      bus.dump_ready = ((c % 4) == 0) || ((c % 4) == 3);
      tick();
    end
    chk("dump2_finish", 64'(busy), 0);
    bus.dump_ready = 1'b1;
    tick();
    chk("dump2_beats", 64'(hs_total - base), 32);
    chk("dump2_done_count", 64'(done_total - dbase), 1);

    // Load regs 1..31, reg 0 skipped.
    for (int i = 1; i < NREGS; i++) begin
      b.idx  = IW'(i);
      b.data = 32'hA000_0000 + 32'(i);
      exp_wr.push_back(b);
    end
    dbase = done_total;
    pulse(1'b0, 1'b1);
    for (int i = 1; i < NREGS; i++) load_beat(32'hA000_0000 + 32'(i));
    wait_idle("load_finish");
    tick();
    chk("load_reg5", 64'(rf[5]), 64'h0000_0000_A000_0005);
    chk("load_reg31", 64'(rf[31]), 64'h0000_0000_A000_001F);
    chk("load_reg0_untouched", 64'(rf[0]), 0);
    chk("load_done_count", 64'(done_total - dbase), 1);

    // Simultaneous starts: dump wins; a mid-dump start_load is ignored.
    push_dump(0, 31, 1'b1);
    base = hs_total;
    dbase = done_total;
    pulse(1'b1, 1'b1);
    repeat (5) tick();
    pulse(1'b0, 1'b1);
    wait_idle("both_finish");
    tick();
    chk("both_beats", 64'(hs_total - base), 32);
    chk("both_done_count", 64'(done_total - dbase), 1);

    // Abort after 10 beats, then restart.
    push_dump(0, 9, 1'b1);
    base = hs_total;
    dbase = done_total;
    pulse(1'b1, 1'b0);
    repeat (11) tick();
    bus.dump_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_dump_valid", 64'(bus.dump_valid), 0);
    chk("abort_busy", 64'(busy), 0);
    repeat (3) tick();
    chk("abort_beats", 64'(hs_total - base), 10);
    chk("abort_no_done", 64'(done_total - dbase), 0);
    bus.dump_ready = 1'b1;
    push_dump(0, 31, 1'b1);
    base = hs_total;
    pulse(1'b1, 1'b0);
    wait_idle("restart_finish");
    tick();
    chk("restart_beats", 64'(hs_total - base), 32);
    chk("restart_done_count", 64'(done_total - dbase), 1);

    // Reset during load after four writes.
    for (int i = 1; i <= 4; i++) begin
      b.idx  = IW'(i);
      b.data = 32'hB000_0000 + 32'(i);
      exp_wr.push_back(b);
    end
    pulse(1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) load_beat(32'hB000_0000 + 32'(i));
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hB000_0005;
    #2;
    n_rst = 1'b0;
    #1;
    check_idle_outputs("midreset");
    bus.load_valid = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    chk("midreset_idle_after", 64'(busy), 0);
    chk("midreset_reg1", 64'(rf[1]), 64'h0000_0000_B000_0001);
    chk("midreset_reg4", 64'(rf[4]), 64'h0000_0000_B000_0004);
    chk("midreset_reg5_old", 64'(rf[5]), 64'h0000_0000_A000_0005);
    chk("final_queues_empty", 64'(exp_dump.size() + exp_wr.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
